reg_file_32x32: RTL and testbench
=================================

Name: reg_file_32x32

Overview:
- 32-entry x 32-bit general-purpose register file. Sits directly downstream of the write-address select mux.
- Consumes the selected 5-bit `writeaddress` together with the write-back data and write enable.
- Provides two combinational read ports to the decode/ALU stage.
- Optional write-through bypass lets a same-cycle read of the register being written return the new value.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.
- ZERO_HARDWIRED, 1, when 1 register 0 always reads 0 and ignores writes; when 0 register 0 is an ordinary register.
- BYPASS_EN, 1, when 1 enables combinational write-to-read forwarding within the same cycle.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high; clears all registers.
- regwrite  input  1  write enable for the current cycle.
- writeaddress  input  ADDR_W  destination register index (from the write-address select mux).
- writedata  input  DATA_W  value to store.
- readaddr1  input  ADDR_W  source register index, port 1.
- readaddr2  input  ADDR_W  source register index, port 2.
- readdata1  output  DATA_W  contents of readaddr1.
- readdata2  output  DATA_W  contents of readaddr2.

Behaviour:
- Storage:
  - 2**ADDR_W registers of DATA_W bits, implemented as flops (no RAM inference required).
  - Reset value of every register is 0.
- Reset:
  - Assertion of rst clears all registers immediately, without waiting for clk.
  - While rst is high, no write takes effect, regardless of regwrite.
  - Read ports remain combinational during reset and therefore return 0.
  - Reset mid-operation: a write coinciding with the rst rising edge is lost.
  - First write after release: the first rising clk edge with rst low and regwrite high.
- Write:
  - On rising clk, if rst = 0 and regwrite = 1, the register at writeaddress takes writedata.
  - Exception: when ZERO_HARDWIRED = 1 and writeaddress = 0, the write is discarded.
  - Write latency: 1 cycle. The value is visible from storage after the edge.
  - When regwrite = 0, no register changes. writeaddress and writedata are don't-care.
- Read:
  - Purely combinational; latency 0.
  - readdataN = reg[readaddrN], subject to the zero and bypass rules below.
  - Zero rule: when ZERO_HARDWIRED = 1 and readaddrN = 0, readdataN = 0 unconditionally. This rule takes priority over bypass.
  - Bypass rule: when BYPASS_EN = 1 and regwrite = 1 and rst = 0 and writeaddress = readaddrN, readdataN = writedata in the same cycle.
  - Bypass applies to each port independently; both ports may bypass simultaneously.
  - When BYPASS_EN = 0, the same-cycle read returns the old value and the new value appears after the edge.
- Simultaneous events:
  - readaddr1 = readaddr2: both ports return identical data.
  - Write and read of different indices in the same cycle are independent.
- No X propagation: all reads of never-written registers return 0 after reset.
- No internal state machine. All sequential behaviour is the per-register enable flop with async clear.

Test Plan:
1. Assert rst for 2 cycles, then sweep readaddr1/readaddr2 over 0..31. Required: all reads = 0x00000000.
2. Write 0xDEADBEEF to r5 (regwrite = 1, writeaddress = 5), then read r5 on both ports the next cycle. Required: 0xDEADBEEF on both ports. Also read r4 and r6. Required: both = 0.
3. ZERO_HARDWIRED = 1: write 0x12345678 to r0, then read r0 in the same cycle and the next cycle. Required: 0 both times. Bypass must not fire for r0.
4. BYPASS_EN = 1: r7 holds 0x11111111; in one cycle present regwrite = 1, writeaddress = 7, writedata = 0x22222222, readaddr1 = 7. Required: readdata1 = 0x22222222 before the edge.
   - Repeat with BYPASS_EN = 0. Required: 0x11111111 before the edge, 0x22222222 after it.
5. Fill r1..r31 with value = index * 0x01010101, assert rst asynchronously between clock edges, and check readdata immediately. Required: all reads = 0 before the next clk edge.
   - Release rst and apply a write on the same cycle's edge. Required: that write takes effect only when rst is already low at the edge.
6. regwrite = 0 with writeaddress = 9 and writedata = 0xFFFFFFFF for 3 cycles after r9 = 0xAAAAAAAA. Required: r9 reads 0xAAAAAAAA throughout, on both ports.

Source files
------------

// File: rtl/reg_file_32x32.sv
// 32x32 general-purpose register file: flop storage with async clear,
// two combinational read ports with optional same-cycle write forwarding.

module reg_file_32x32_rd_port #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int ZERO_HARDWIRED = 1,
  parameter int BYPASS_EN      = 1
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                  raddr,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
  input  logic                               wen,
  output logic [DATA_W-1:0]                  rdata
);
  // Zero rule is applied last so it overrides forwarding.
  always_comb begin
    rdata = mem[raddr];
    if (BYPASS_EN != 0 && wen && waddr == raddr) rdata = wdata;
    if (ZERO_HARDWIRED != 0 && raddr == '0)      rdata = '0;
  end
endmodule

module reg_file_32x32 #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int ZERO_HARDWIRED = 1,
  parameter int BYPASS_EN      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] writeaddress,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] readaddr1,
  input  logic [ADDR_W-1:0] readaddr2,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;
  logic                          wen;

  // Forwarding is suppressed while reset holds storage at zero.
  assign wen = regwrite & ~rst;

  always_comb begin
    mem_d = mem_q;
    if (regwrite && !(ZERO_HARDWIRED != 0 && writeaddress == '0))
      mem_d[writeaddress] = writedata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign raddr = {readaddr2, readaddr1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_32x32_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .ZERO_HARDWIRED(ZERO_HARDWIRED), .BYPASS_EN(BYPASS_EN)
    ) u_rd (
      .mem(mem_q), .raddr(raddr[p]), .waddr(writeaddress),
      .wdata(writedata), .wen(wen), .rdata(rdata[p])
    );
  end

  assign readdata1 = rdata[0];
  assign readdata2 = rdata[1];
endmodule

// File: tb/tb_reg_file_32x32.sv
// Bench for reg_file_32x32: a bypass-enabled and a bypass-disabled instance
// share stimulus; expected read data is queued at drive time and popped at sample.

module tb_reg_file_32x32;
  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite;
  logic [4:0]  writeaddress, readaddr1, readaddr2;
  logic [31:0] writedata;
  logic [31:0] rd1_bp, rd2_bp, rd1_nb, rd2_nb;

  always #5 clk = ~clk;

  reg_file_32x32 #(.BYPASS_EN(1)) dut_bp (
    .clk(clk), .rst(rst), .regwrite(regwrite), .writeaddress(writeaddress),
    .writedata(writedata), .readaddr1(readaddr1), .readaddr2(readaddr2),
    .readdata1(rd1_bp), .readdata2(rd2_bp)
  );

  reg_file_32x32 #(.BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst(rst), .regwrite(regwrite), .writeaddress(writeaddress),
    .writedata(writedata), .readaddr1(readaddr1), .readaddr2(readaddr2),
    .readdata1(rd1_nb), .readdata2(rd2_nb)
  );

  typedef struct {
    string       nm;
    logic [31:0] e1, e2, n1, n2;
  } exp_t;

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2, n1, n2;
  } vec_t;

  exp_t sb[$];
  vec_t vt[14];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(bit we, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] e1, logic [31:0] e2,
                              logic [31:0] n1, logic [31:0] n2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.a1 = a1; v.a2 = a2;
    v.e1 = e1; v.e2 = e2; v.n1 = n1; v.n2 = n2;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] n1, input logic [31:0] n2);
    exp_t x;
    x.nm = nm; x.e1 = e1; x.e2 = e2; x.n1 = n1; x.n2 = n2;
    sb.push_back(x);
  endtask

  task automatic apply(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] n1, input logic [31:0] n2, input string nm);
    regwrite = we; writeaddress = wa; writedata = wd;
    readaddr1 = a1; readaddr2 = a2;
    push_exp(nm, e1, e2, n1, n2);
  endtask

  task automatic score();
    exp_t x;
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      x = sb.pop_front();
      cmp({x.nm, ".bp1"}, rd1_bp, x.e1);
      cmp({x.nm, ".bp2"}, rd2_bp, x.e2);
      cmp({x.nm, ".nb1"}, rd1_nb, x.n1);
      cmp({x.nm, ".nb2"}, rd2_nb, x.n2);
    end
  endtask

  initial begin
    // we wa wd a1 a2 | bypass-on port1/2 | bypass-off port1/2
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 5, 4, 32'hDEADBEEF, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    vt[2]  = mk(0, 0, 0, 4, 6, 0, 0, 0, 0);
    vt[3]  = mk(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(1, 7, 32'h11111111, 0, 7, 0, 32'h11111111, 0, 0);
    vt[6]  = mk(1, 7, 32'h22222222, 7, 5, 32'h22222222, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF);
    vt[7]  = mk(0, 0, 0, 7, 7, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
    vt[8]  = mk(1, 9, 32'hAAAAAAAA, 9, 7, 32'hAAAAAAAA, 32'h22222222, 0, 32'h22222222);
    vt[9]  = mk(0, 9, 32'hFFFFFFFF, 9, 9, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA);
    vt[10] = mk(0, 9, 32'hFFFFFFFF, 9, 9, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA);
    vt[11] = mk(0, 9, 32'hFFFFFFFF, 9, 9, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA);
    vt[12] = mk(1, 3, 32'h00000033, 3, 3, 32'h33, 32'h33, 0, 0);
    vt[13] = mk(1, 4, 32'h00000044, 3, 9, 32'h33, 32'hAAAAAAAA, 32'h33, 32'hAAAAAAAA);

    rst = 1'b1; regwrite = 1'b0; writeaddress = '0; writedata = '0;
    readaddr1 = '0; readaddr2 = '0;

    // Reset: a write presented under reset neither forwards nor lands.
    repeat (2) @(negedge clk);
    apply(1, 5, 32'hFFFFFFFF, 5, 1, 0, 0, 0, 0, "rst_hold");
    score();
    @(negedge clk);
    rst = 1'b0;
    regwrite = 1'b0;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      apply(0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, $sformatf("sweep%0d", i));
      score();
    end

    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      apply(vt[k].we, vt[k].wa, vt[k].wd, vt[k].a1, vt[k].a2,
            vt[k].e1, vt[k].e2, vt[k].n1, vt[k].n2, $sformatf("vec%0d", k));
      score();
    end

    // Fill r1..r31 with index * 0x01010101 and read it all back.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      regwrite = 1'b1; writeaddress = 5'(i); writedata = i * 32'h01010101;
    end
    for (int i = 1; i < 32; i++) begin
      logic [31:0] v1, v2;
      v1 = i * 32'h01010101;
      v2 = (i == 31) ? 32'h01010101 : (i + 1) * 32'h01010101;
      @(negedge clk);
      apply(0, 0, 0, 5'(i), (i == 31) ? 5'd1 : 5'(i + 1), v1, v2, v1, v2,
            $sformatf("fill%0d", i));
      score();
    end

    // Async reset between edges with a write pending: reads drop to 0 at once.
    @(negedge clk);
    regwrite = 1'b1; writeaddress = 5'd10; writedata = 32'hA5A5A5A5;
    readaddr1 = 5'd10; readaddr2 = 5'd31;
    #2 rst = 1'b1;
    push_exp("async_rst", 0, 0, 0, 0);
    score();

    // rst falls before the next edge: that edge's write is the first to land.
    @(negedge clk);
    rst = 1'b0;
    apply(1, 11, 32'h5A5A5A5A, 10, 11, 0, 32'h5A5A5A5A, 0, 0, "rel_wr");
    score();
    @(negedge clk);
    apply(0, 0, 0, 10, 11, 0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, "rel_post");
    score();
    @(negedge clk);
    apply(0, 0, 0, 31, 31, 0, 0, 0, 0, "rst_cleared");
    score();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
